// File: rtl/muldiv_seq_pkg.sv
// Shared MIPS definitions used by the mul/div sequencer: operation encoding,
// iteration count and the sequencer state type.
package muldiv_seq_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } mdop_t;

   localparam int MD_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_t;

endpackage

// File: rtl/muldiv_seq_md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Upper half holds P_hi / remainder, lower half holds P_lo (multiplier) / quotient.
module md_step #(
   parameter int W = 32
) (
   input  logic         is_div,
   input  logic [W-1:0] acc_hi,
   input  logic [W-1:0] acc_lo,
   input  logic [W-1:0] opnd,
   output logic [W-1:0] nxt_hi,
   output logic [W-1:0] nxt_lo
);

   logic [W:0]   sum_s;
   logic [W:0]   rsh_s;
   logic [W-1:0] diff_s;

   // Remainder is always below the divisor, so a successful trial fits in W bits.
   always_comb begin
      sum_s  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      rsh_s  = {acc_hi, acc_lo[W-1]};
      diff_s = rsh_s[W-1:0] - opnd;
      if (is_div) begin
         if (rsh_s >= {1'b0, opnd}) begin
            nxt_hi = diff_s;
            nxt_lo = {acc_lo[W-2:0], 1'b1};
         end else begin
            nxt_hi = rsh_s[W-1:0];
            nxt_lo = {acc_lo[W-2:0], 1'b0};
         end
      end else begin
         nxt_hi = sum_s[W:1];
         nxt_lo = {sum_s[0], acc_lo[W-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO,
// with single-cycle MTHI/MTLO and a busy/done handshake for the pipeline.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  mdop_t        op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         flush,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   md_state_t    state_r;
   logic [5:0]   cnt_r;
   logic         is_div_r;
   logic         neg_res_r;
   logic         neg_rem_r;
   logic         dz_r;
   logic [W-1:0] a_lat_r;
   logic [W-1:0] acc_hi_r;
   logic [W-1:0] acc_lo_r;
   logic [W-1:0] opnd_r;

   logic         is_signed_s;
   logic         is_div_s;
   logic [W-1:0] mag_a_s;
   logic [W-1:0] mag_b_s;
   logic [W-1:0] step_hi_s;
   logic [W-1:0] step_lo_s;
   logic [2*W-1:0] prod_s;
   logic [W-1:0] fix_hi_s;
   logic [W-1:0] fix_lo_s;

   // Operand decode at issue: signedness, unit select and magnitudes.
   always_comb begin
      is_signed_s = (op == MD_MULT) || (op == MD_DIV);
      is_div_s    = (op == MD_DIV)  || (op == MD_DIVU);
      mag_a_s     = (is_signed_s && a[W-1]) ? ({W{1'b0}} - a) : a;
      mag_b_s     = (is_signed_s && b[W-1]) ? ({W{1'b0}} - b) : b;
   end

   md_step #(.W(W)) u_step (
      .is_div (is_div_r),
      .acc_hi (acc_hi_r),
      .acc_lo (acc_lo_r),
      .opnd   (opnd_r),
      .nxt_hi (step_hi_s),
      .nxt_lo (step_lo_s)
   );

   // Sign fix-up of the unsigned core result; divide by zero bypasses it.
   always_comb begin
      prod_s = {acc_hi_r, acc_lo_r};
      if (neg_res_r) begin
         prod_s = {(2*W){1'b0}} - prod_s;
      end else begin
         prod_s = {acc_hi_r, acc_lo_r};
      end
      if (!is_div_r) begin
         fix_hi_s = prod_s[2*W-1:W];
         fix_lo_s = prod_s[W-1:0];
      end else if (dz_r) begin
         fix_hi_s = a_lat_r;
         fix_lo_s = {W{1'b1}};
      end else begin
         fix_hi_s = neg_rem_r ? ({W{1'b0}} - acc_hi_r) : acc_hi_r;
         fix_lo_s = neg_res_r ? ({W{1'b0}} - acc_lo_r) : acc_lo_r;
      end
   end

   // Sequencer FSM, operand latches and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 6'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hi        <= {W{1'b0}};
         lo        <= {W{1'b0}};
         is_div_r  <= 1'b0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         dz_r      <= 1'b0;
         a_lat_r   <= {W{1'b0}};
         acc_hi_r  <= {W{1'b0}};
         acc_lo_r  <= {W{1'b0}};
         opnd_r    <= {W{1'b0}};
      end else if (flush) begin
         state_r <= ST_IDLE;
         cnt_r   <= 6'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  case (op)
                     MD_MTHI: hi <= a;
                     MD_MTLO: lo <= a;
                     MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        state_r   <= ST_CALC;
                        busy      <= 1'b1;
                        cnt_r     <= 6'd0;
                        is_div_r  <= is_div_s;
                        neg_res_r <= is_signed_s && (a[W-1] ^ b[W-1]);
                        neg_rem_r <= is_signed_s && a[W-1];
                        dz_r      <= (b == {W{1'b0}});
                        a_lat_r   <= a;
                        acc_hi_r  <= {W{1'b0}};
                        acc_lo_r  <= is_div_s ? mag_a_s : mag_b_s;
                        opnd_r    <= is_div_s ? mag_b_s : mag_a_s;
                     end
                     default: state_r <= ST_IDLE;
                  endcase
               end
            end
            ST_CALC: begin
               acc_hi_r <= step_hi_s;
               acc_lo_r <= step_lo_s;
               cnt_r    <= cnt_r + 6'd1;
               if (cnt_r == 6'(MD_ITER - 1)) begin
                  state_r <= ST_FIX;
               end
            end
            ST_FIX: begin
               hi      <= fix_hi_s;
               lo      <= fix_lo_s;
               state_r <= ST_IDLE;
               cnt_r   <= 6'd0;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized bench for muldiv_seq against a plain-arithmetic model of HI/LO.
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   mdop_t       op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_hi   = 32'd0;
   logic [31:0] exp_lo   = 32'd0;

   always #5 clk = ~clk;

   muldiv_seq #(.W(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Architectural effect of one operation on HI/LO.
   function automatic void model(input mdop_t o, input logic [31:0] x, input logic [31:0] y,
                                 inout logic [31:0] mh, inout logic [31:0] ml);
      longint sx, sy, sr;
      longint unsigned ux, uy, ur;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         MD_MULT:  begin sr = sx * sy; mh = sr[63:32]; ml = sr[31:0]; end
         MD_MULTU: begin ur = ux * uy; mh = ur[63:32]; ml = ur[31:0]; end
         MD_DIV, MD_DIVU: begin
            if (y == 32'd0) begin
               mh = x;
               ml = 32'hFFFF_FFFF;
            end else if (o == MD_DIV) begin
               sr = sx / sy; ml = sr[31:0];
               sr = sx % sy; mh = sr[31:0];
            end else begin
               ur = ux / uy; ml = ur[31:0];
               ur = ux % uy; mh = ur[31:0];
            end
         end
         MD_MTHI: mh = x;
         MD_MTLO: ml = x;
         default: ;
      endcase
   endfunction

   // Issue one op in the current cycle (T) and check timing and result.
   task automatic run(input mdop_t o, input logic [31:0] x, input logic [31:0] y, input string tag);
      int bad;
      op = o; a = x; b = y; start = 1'b1;
      model(o, x, y, exp_hi, exp_lo);
      tick;
      start = 1'b0;
      if (o == MD_MTHI || o == MD_MTLO) begin
         check({tag, "_mt_busy"}, {31'd0, busy}, 32'd0);
         check({tag, "_mt_done"}, {31'd0, done}, 32'd0);
         check({tag, "_hi"}, hi, exp_hi);
         check({tag, "_lo"}, lo, exp_lo);
      end else begin
         bad = 0;
         for (int i = 1; i <= 33; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            a = $urandom;
            b = $urandom;
            tick;
         end
         check({tag, "_busy_window"}, bad, 32'd0);
         check({tag, "_done"}, {31'd0, done}, 32'd1);
         check({tag, "_idle"}, {31'd0, busy}, 32'd0);
         check({tag, "_hi"}, hi, exp_hi);
         check({tag, "_lo"}, lo, exp_lo);
      end
   endtask

   initial begin
      int          bad;
      mdop_t       ro;
      logic [31:0] rx, ry;

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = MD_MULT; a = 32'd0; b = 32'd0;
      tick;
      tick;
      rst = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);

      // Back-to-back ops: each start lands in the previous done cycle.
      run(MD_MULT, 32'hFFFF_FFFF, 32'd5, "mult_m1x5");
      check("mult_m1x5_hi_const", hi, 32'hFFFF_FFFF);
      check("mult_m1x5_lo_const", lo, 32'hFFFF_FFFB);
      run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
      run(MD_DIVU, 32'd7, 32'd2, "divu_7_2");
      run(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      check("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
      run(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
      check("div_wrap_lo_const", lo, 32'h8000_0000);
      run(MD_DIV, 32'h1234_5678, 32'd0, "div_by_zero");
      check("div_by_zero_lo_const", lo, 32'hFFFF_FFFF);
      run(MD_DIVU, 32'h8765_4321, 32'd0, "divu_by_zero");
      tick;
      run(MD_MTHI, 32'hDEAD_BEEF, 32'd0, "mthi");
      run(MD_MTLO, 32'h0BAD_F00D, 32'd0, "mtlo");

      // Flush at T+10 with an ignored start at T+5.
      op = MD_MULT; a = 32'd3; b = 32'd7; start = 1'b1;
      tick;
      start = 1'b0;
      bad = 0;
      for (int k = 1; k <= 9; k++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad++;
         start = (k == 5);
         op = MD_MULTU; a = 32'h1111_1111; b = 32'h2;
         tick;
      end
      start = 1'b0;
      check("flush_pre_busy", bad, 32'd0);
      check("flush_t10_done", {31'd0, done}, 32'd0);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_hi", hi, exp_hi);
      check("flush_lo", lo, exp_lo);
      bad = 0;
      for (int k = 11; k <= 40; k++) begin
         if (done !== 1'b0 || busy !== 1'b0) bad++;
         tick;
      end
      check("flush_no_done", bad, 32'd0);

      // Flush together with start: start is dropped.
      op = MD_MTHI; a = 32'h5555_AAAA; start = 1'b1; flush = 1'b1;
      tick;
      start = 1'b0; flush = 1'b0;
      check("flush_start_hi", hi, exp_hi);
      check("flush_start_busy", {31'd0, busy}, 32'd0);

      // Flush in the FIX cycle: HI/LO must not be written.
      op = MD_DIVU; a = 32'd100; b = 32'd9; start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 1; k <= 32; k++) tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      check("fix_flush_done", {31'd0, done}, 32'd0);
      check("fix_flush_busy", {31'd0, busy}, 32'd0);
      check("fix_flush_hi", hi, exp_hi);
      check("fix_flush_lo", lo, exp_lo);

      // Randomized operations, including zero divisors and MT ops.
      for (int n = 0; n < 24; n++) begin
         ro = mdop_t'($urandom_range(0, 5));
         rx = $urandom;
         ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) ry = ry & 32'h0000_00FF;
         run(ro, rx, ry, "rand");
      end

      // Reset in the middle of a DIVU.
      op = MD_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         if (done !== 1'b0) bad++;
         tick;
      end
      check("midrst_no_done", bad, 32'd0);
      run(MD_MULT, 32'h8000_0000, 32'h8000_0000, "post_rst_mult");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
